// File: rtl/emulib_rammodel_encoder_w_if.sv
// emulib_rammodel_encoder_w_if: AXI4 W beat channel plus the 32-bit transport word stream
interface emulib_rammodel_encoder_w_if #(
   parameter int DATA_WIDTH = 64
);
   logic                    axi_wvalid;
   logic                    axi_wready;
   logic [DATA_WIDTH-1:0]   axi_wdata;
   logic [DATA_WIDTH/8-1:0] axi_wstrb;
   logic                    axi_wlast;
   logic                    data_valid;
   logic                    data_ready;
   logic [31:0]             data;
   modport master (
      output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, data_ready,
      input  axi_wready, data_valid, data
   );
   modport slave (
      input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, data_ready,
      output axi_wready, data_valid, data
   );
endinterface

// File: rtl/emulib_rammodel_encoder_w.sv
// emulib_rammodel_encoder_w: buffers AXI4 W beats two deep and serializes each into HEAD/DATA words
module emulib_rammodel_encoder_w #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   emulib_rammodel_encoder_w_if.slave   w,
   output logic                         idle
);
   localparam int  SW      = DATA_WIDTH / 8;
   localparam int  EW      = DATA_WIDTH + SW + 1;
   localparam bit  DATA_32 = (DATA_WIDTH <= 32);
   if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64) ||
       ADDR_WIDTH < 1 || ID_WIDTH < 1) begin : g_bad_params
      $error("emulib_rammodel_encoder_w: unsupported parameters");
   end
   typedef enum logic [1:0] {S_HEAD, S_DATA_1, S_DATA_2} state_t;
   state_t                 state, state_next;
   logic [EW-1:0]          mem [2];
   logic [1:0]             count, count_next;
   logic                   wr_ptr, rd_ptr, wready_q, push, pop, fire;
   logic [EW-1:0]          head;
   logic [DATA_WIDTH-1:0]  head_d;
   logic [SW-1:0]          head_s;
   logic                   head_l;
   logic [31:0]            data_lo, data_hi;
   assign push = w.axi_wvalid && wready_q;
   assign fire = w.data_valid && w.data_ready;
   assign pop  = fire && (state == S_DATA_2 || (state == S_DATA_1 && DATA_32));
   assign count_next = count + {1'b0, push} - {1'b0, pop};
   always_comb begin
      state_next = !fire ? state :
                   state == S_HEAD ? S_DATA_1 :
                   (state == S_DATA_1 && !DATA_32) ? S_DATA_2 : S_HEAD;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= 2'd0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         state    <= S_HEAD;
         wready_q <= 1'b0;
      end else begin
         count    <= count_next;
         wr_ptr   <= wr_ptr ^ push;
         rd_ptr   <= rd_ptr ^ pop;
         state    <= state_next;
         wready_q <= count_next < 2'd2;
      end
   end
   // Storage carries no reset; entries are only read once count says they are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {w.axi_wlast, w.axi_wstrb, w.axi_wdata};
   end
   assign head = mem[rd_ptr];
   assign {head_l, head_s, head_d} = head;
   if (DATA_32) begin : g_narrow
      assign data_lo = 32'(head_d);
      assign data_hi = 32'd0;
   end else begin : g_wide
      assign data_lo = head_d[31:0];
      assign data_hi = head_d[63:32];
   end
   assign w.axi_wready = wready_q;
   assign w.data_valid = count != 2'd0;
   assign w.data = state == S_HEAD ? {8'd0, 8'(head_s), 15'd0, head_l} :
                   state == S_DATA_1 ? data_lo : data_hi;
   assign idle = count == 2'd0 && state == S_HEAD;
endmodule

// File: tb/tb_emulib_rammodel_encoder_w.sv
// tb_emulib_rammodel_encoder_w: directed and random-stall checks of the 64-bit and 32-bit serializers
module tb_emulib_rammodel_encoder_w;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic idle_a, idle_b;
   int   passed = 0;
   int   total = 0;
   logic [31:0] qa[$];
   logic [31:0] qb[$];
   always #5 clk = ~clk;
   emulib_rammodel_encoder_w_if #(.DATA_WIDTH(64)) a_if();
   emulib_rammodel_encoder_w_if #(.DATA_WIDTH(32)) b_if();
   emulib_rammodel_encoder_w #(.DATA_WIDTH(64)) dut_a (.clk(clk), .rst_n(rst_n), .w(a_if), .idle(idle_a));
   emulib_rammodel_encoder_w #(.DATA_WIDTH(32)) dut_b (.clk(clk), .rst_n(rst_n), .w(b_if), .idle(idle_b));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send_a(input logic [63:0] d, input logic [7:0] s, input logic l);
      int n = 0;
      a_if.axi_wvalid = 1'b1;
      a_if.axi_wdata  = d;
      a_if.axi_wstrb  = s;
      a_if.axi_wlast  = l;
      while (!a_if.axi_wready && n < 100) begin
         tick();
         n++;
      end
      if (!a_if.axi_wready) chk("a_wready_timeout", 32'(a_if.axi_wready), 32'd1);
      else begin
         qa.push_back({8'd0, s, 15'd0, l});
         qa.push_back(d[31:0]);
         qa.push_back(d[63:32]);
         tick();
      end
   endtask
   task automatic send_b(input logic [31:0] d, input logic [3:0] s, input logic l);
      int n = 0;
      b_if.axi_wvalid = 1'b1;
      b_if.axi_wdata  = d;
      b_if.axi_wstrb  = s;
      b_if.axi_wlast  = l;
      while (!b_if.axi_wready && n < 100) begin
         tick();
         n++;
      end
      if (!b_if.axi_wready) chk("b_wready_timeout", 32'(b_if.axi_wready), 32'd1);
      else begin
         qb.push_back({8'd0, 4'd0, s, 15'd0, l});
         qb.push_back(d);
         tick();
      end
   endtask
   task automatic drain_a();
      int n = 0;
      while ((qa.size() != 0 || !idle_a) && n < 300) begin
         tick();
         n++;
      end
      chk("a_drain_idle", 32'(idle_a), 32'd1);
   endtask
   always @(negedge clk) begin
      if (rst_n && a_if.data_valid && a_if.data_ready) begin
         if (qa.size() == 0) chk("a_unexpected_word", a_if.data, 32'hxxxxxxxx);
         else chk("a_word", a_if.data, qa.pop_front());
      end
      if (rst_n && b_if.data_valid && b_if.data_ready) begin
         if (qb.size() == 0) chk("b_unexpected_word", b_if.data, 32'hxxxxxxxx);
         else chk("b_word", b_if.data, qb.pop_front());
      end
   end
   initial begin
      logic [31:0] held;
      a_if.axi_wvalid = 1'b0; a_if.axi_wdata = '0; a_if.axi_wstrb = '0; a_if.axi_wlast = 1'b0;
      b_if.axi_wvalid = 1'b0; b_if.axi_wdata = '0; b_if.axi_wstrb = '0; b_if.axi_wlast = 1'b0;
      a_if.data_ready = 1'b1;
      b_if.data_ready = 1'b1;
      #1;
      chk("rst_wready", 32'(a_if.axi_wready), 32'd0);
      chk("rst_valid", 32'(a_if.data_valid), 32'd0);
      chk("rst_idle", 32'(idle_a), 32'd1);
      chk("rst_b_wready", 32'(b_if.axi_wready), 32'd0);
      #11 rst_n = 1'b1;
      tick();
      chk("wready_after_rst", 32'(a_if.axi_wready), 32'd1);
      chk("b_wready_after_rst", 32'(b_if.axi_wready), 32'd1);
      // single 64-bit beat, words on consecutive cycles
      send_a(64'h1122334455667788, 8'hA5, 1'b1);
      a_if.axi_wvalid = 1'b0;
      chk("t1_valid", 32'(a_if.data_valid), 32'd1);
      chk("t1_head", a_if.data, 32'h00A50001);
      tick();
      chk("t1_d1", a_if.data, 32'h55667788);
      tick();
      chk("t1_d2", a_if.data, 32'h11223344);
      tick();
      chk("t1_idle", 32'(idle_a), 32'd1);
      chk("t1_valid_low", 32'(a_if.data_valid), 32'd0);
      // 32-bit instance: exactly two words
      send_b(32'hDEADBEEF, 4'h3, 1'b0);
      b_if.axi_wvalid = 1'b0;
      chk("t2_head", b_if.data, 32'h00030000);
      tick();
      chk("t2_d1", b_if.data, 32'hDEADBEEF);
      chk("t2_valid", 32'(b_if.data_valid), 32'd1);
      tick();
      chk("t2_popped", 32'(b_if.data_valid), 32'd0);
      chk("t2_idle", 32'(idle_b), 32'd1);
      // backpressure: two beats fill the buffer, third waits
      a_if.data_ready = 1'b0;
      send_a(64'hA0A1A2A3A4A5A6A7, 8'h0F, 1'b0);
      send_a(64'hB0B1B2B3B4B5B6B7, 8'hF0, 1'b1);
      a_if.axi_wdata = 64'hC0C1C2C3C4C5C6C7;
      a_if.axi_wstrb = 8'hFF;
      a_if.axi_wlast = 1'b0;
      chk("bp_full_wready", 32'(a_if.axi_wready), 32'd0);
      held = a_if.data;
      chk("bp_head", held, 32'h000F0000);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_valid", 32'(a_if.data_valid), 32'd1);
         chk("bp_stable", a_if.data, held);
         chk("bp_wready", 32'(a_if.axi_wready), 32'd0);
      end
      a_if.data_ready = 1'b1;
      tick();
      chk("bp_rel1", 32'(a_if.axi_wready), 32'd0);
      tick();
      chk("bp_rel2", 32'(a_if.axi_wready), 32'd0);
      tick();
      chk("bp_after_pop", 32'(a_if.axi_wready), 32'd1);
      send_a(64'hC0C1C2C3C4C5C6C7, 8'hFF, 1'b0);
      a_if.axi_wvalid = 1'b0;
      drain_a();
      // random stall on a 4-beat burst
      fork
         begin
            for (int i = 0; i < 4; i++)
               send_a({$urandom(), $urandom()}, 8'($urandom_range(0, 255)), i == 3);
            a_if.axi_wvalid = 1'b0;
         end
         begin
            repeat (60) begin
               tick();
               a_if.data_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      a_if.data_ready = 1'b1;
      drain_a();
      // reset after the DATA_1 word has fired
      send_a(64'h0123456789ABCDEF, 8'h3C, 1'b1);
      a_if.axi_wvalid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(a_if.data_valid), 32'd0);
      chk("mid_rst_wready", 32'(a_if.axi_wready), 32'd0);
      chk("mid_rst_idle", 32'(idle_a), 32'd1);
      qa.delete();
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_wready", 32'(a_if.axi_wready), 32'd1);
      send_a(64'hFEDCBA9876543210, 8'h81, 1'b0);
      a_if.axi_wvalid = 1'b0;
      chk("post_rst_head", a_if.data, 32'h00810000);
      drain_a();
      // push lands on the same edge as the final-word pop
      send_a(64'h1111111122222222, 8'h11, 1'b0);
      a_if.axi_wvalid = 1'b0;
      tick();
      tick();
      send_a(64'h3333333344444444, 8'h5A, 1'b1);
      a_if.axi_wvalid = 1'b0;
      chk("pp_wready", 32'(a_if.axi_wready), 32'd1);
      chk("pp_valid", 32'(a_if.data_valid), 32'd1);
      chk("pp_head", a_if.data, 32'h005A0001);
      tick();
      chk("pp_wready_hold", 32'(a_if.axi_wready), 32'd1);
      drain_a();
      chk("a_sb_empty", 32'(qa.size()), 32'd0);
      chk("b_sb_empty", 32'(qb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
